// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, default latencies and the divide-by-zero rule for the MIPS multiply/divide unit.
// Ops 6..9 (MADD family) only take effect when MDU_MADD_EN is defined.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;
    localparam int MDU_MAXW        = 64;

    // Returns {hi, lo} for a zero divisor: hi keeps the dividend, lo saturates to all ones.
    function automatic logic [2*MDU_MAXW-1:0] div_by_zero(input logic [MDU_MAXW-1:0] dividend);
        return {dividend, {MDU_MAXW{1'b1}}};
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational product/quotient datapath producing the 2*WIDTH {hi,lo} result.
// Multiply-accumulate ops are built only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result
);

    localparam int W2 = 2 * WIDTH;

    logic                    signed_op, is_div, b_zero, ovf;
    logic signed [W2-1:0]    prod_s;
    logic [W2-1:0]           prod_u, prod, dz, div_s, div_u, acc;
    logic signed [WIDTH-1:0] dsor_s, q_s, r_s;
    logic [WIDTH-1:0]        dsor_u, q_u, r_u;
    logic [2*MDU_MAXW-1:0]   dz_wide;

    assign signed_op = op == OP_MULT || op == OP_DIV || op == OP_MADD || op == OP_MSUB;
    assign is_div    = op == OP_DIV || op == OP_DIVU;
    assign b_zero    = b == '0;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign prod   = signed_op ? prod_s : prod_u;

    // Most-negative / -1 is steered to a divisor of 1, which yields exactly lo=a, hi=0 without overflow.
    assign ovf    = a == {1'b1, {(WIDTH-1){1'b0}}} && &b;
    assign dsor_s = (b_zero || ovf) ? WIDTH'(1) : b;
    assign dsor_u = b_zero ? WIDTH'(1) : b;
    assign q_s    = $signed(a) / dsor_s;
    assign r_s    = $signed(a) % dsor_s;
    assign q_u    = a / dsor_u;
    assign r_u    = a % dsor_u;
    assign div_s  = {r_s, q_s};
    assign div_u  = {r_u, q_u};

    assign dz_wide = div_by_zero(MDU_MAXW'(a));
    assign dz      = {WIDTH'(dz_wide[2*MDU_MAXW-1:MDU_MAXW]), WIDTH'(dz_wide[MDU_MAXW-1:0])};

`ifdef MDU_MADD_EN
    logic is_acc;
    assign is_acc = op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU;
    assign acc    = (op == OP_MSUB || op == OP_MSUBU) ? {hi, lo} - prod : {hi, lo} + prod;
    assign result = is_div ? (b_zero ? dz : signed_op ? div_s : div_u) : is_acc ? acc : prod;
`else
    logic unused_acc;
    assign acc        = '0;
    assign unused_acc = ^{hi, lo, acc};
    assign result     = is_div ? (b_zero ? dz : signed_op ? div_s : div_u) : prod;
`endif

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: owns HI/LO, holds a multi-cycle result in a pending register and commits it when busy drops.
// Defining MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops with multiply timing.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0]      count, count_n;
    logic [2*WIDTH-1:0] pending, result;
    logic               accept, is_mul, is_div;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi),
        .lo     (lo),
        .result (result)
    );

`ifdef MDU_MADD_EN
    assign is_mul = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    assign is_mul = op inside {OP_MULT, OP_MULTU};
`endif
    assign is_div = op inside {OP_DIV, OP_DIVU};

    // Starts while an op is in flight are dropped, so a commit never collides with a new op.
    assign accept  = start && count == '0;
    assign count_n = count != '0       ? count - 1'b1 :
                     accept && is_mul  ? CW'(MULT_CYCLES) :
                     accept && is_div  ? CW'(DIV_CYCLES) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            busy    <= 1'b0;
            pending <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            count <= count_n;
            busy  <= count_n != '0;
            if (accept && (is_mul || is_div))
                pending <= result;
            if (count == CW'(1))
                {hi, lo} <= pending;
            else if (accept && op == OP_MTHI)
                hi <= a;
            else if (accept && op == OP_MTLO)
                lo <= a;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic reference model.
// Honours MDU_MADD_EN the same way the design does.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          tests = 0, fails = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (start && !reset) assert (!busy) else $error("start issued while busy");

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                               input logic [31:0] h, input logic [31:0] l);
        longint      ps, qs, rs;
        logic [63:0] pu, xu, yu;
        xu = {32'b0, x};
        yu = {32'b0, y};
        ps = longint'($signed(x)) * longint'($signed(y));
        pu = xu * yu;
        case (o)
            4'd0: return ps;
            4'd1: return pu;
            4'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                qs = longint'($signed(x)) / longint'($signed(y));
                rs = longint'($signed(x)) % longint'($signed(y));
                return {rs[31:0], qs[31:0]};
            end
            4'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                pu = xu / yu;
                xu = xu % yu;
                return {xu[31:0], pu[31:0]};
            end
            4'd4: return {x, l};
            4'd5: return {h, x};
`ifdef MDU_MADD_EN
            4'd6: return {h, l} + ps;
            4'd7: return {h, l} + pu;
            4'd8: return {h, l} - ps;
            4'd9: return {h, l} - pu;
`endif
            default: return {h, l};
        endcase
    endfunction

    function automatic int ref_cycles(input logic [3:0] o);
        if (o <= 4'd1) return 5;
        if (o <= 4'd3) return 10;
`ifdef MDU_MADD_EN
        if (o >= 4'd6 && o <= 4'd9) return 5;
`endif
        return 0;
    endfunction

    // Called at a negedge; returns at the negedge where the result must be visible.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] exp;
        int n;
        exp = ref_result(o, x, y, m_hi, m_lo);
        n = ref_cycles(o);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("busy_op%0d_c%0d", o, i), busy, 1'b1);
            if (i == 0) chk($sformatf("hold_op%0d", o), {hi, lo}, {m_hi, m_lo});
            a = $urandom; b = $urandom;
            @(negedge clk);
        end
        chk($sformatf("idle_op%0d", o), busy, 1'b0);
        chk($sformatf("hilo_op%0d", o), {hi, lo}, exp);
        {m_hi, m_lo} = exp;
    endtask

    initial begin
        logic [31:0] x, y;
        logic [3:0]  o;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(4'd0, 32'hFFFF_FFFE, 32'd3);
        chk("t1", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(4'd3, 32'd100, 32'd7);
        chk("t2_divu", {hi, lo}, {32'd2, 32'd14});
        run_op(4'd2, -32'sd7, 32'd2);
        chk("t2_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd2, 32'h1234, 32'd0);
        chk("t3_dz", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
        run_op(4'd3, 32'h5678, 32'd0);
        chk("t3_dzu", {hi, lo}, {32'h5678, 32'hFFFF_FFFF});
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("t3_ovf", {hi, lo}, {32'd0, 32'h8000_0000});

        run_op(4'd4, 32'hDEAD, 32'd0);
        run_op(4'd5, 32'hBEEF, 32'd0);
        chk("t5_mt", {hi, lo}, {32'hDEAD, 32'hBEEF});
        run_op(4'd0, 32'd6, 32'd7);
        chk("t5_stable", {hi, lo}, 64'd42);

        run_op(4'd4, 32'd0, 32'd0);
        run_op(4'd5, 32'd10, 32'd0);
        run_op(4'd7, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        chk("t6_maddu", {hi, lo}, 64'd22);
`else
        chk("t6_nop", {hi, lo}, 64'd10);
`endif

        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(o, x, y);
        end

        start = 1'b1; op = 4'd0; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t4_busy", busy, 1'b0);
        chk("t4_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (12) @(negedge clk);
        chk("t4_late_busy", busy, 1'b0);
        chk("t4_late_hilo", {hi, lo}, {m_hi, m_lo});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
